btree_sched: RTL and testbench

BTREE_SCHED -- requirements
Module: btree_sched

---
 rtl/btree_pkg.sv | 12 +
 rtl/btree_sched_fifo.sv | 50 +++++
 rtl/btree_sched.sv | 164 ++++++++++++++++
 tb/tb_btree_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btree_pkg.sv
// Shared defaults and types for the reduction-tree scheduler.
package btree_pkg;

  localparam int W_DEF     = 32;
  localparam int LANES_DEF = 8;
  localparam int NREQ_DEF  = 4;
  localparam int ID_W_DEF  = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

  // Requester index as carried alongside each tree issue
  typedef logic [ID_W_DEF-1:0] req_id_t;

endpackage

// File: rtl/btree_sched_fifo.sv
// Response FIFO: registered pointers/occupancy, head visible combinationally,
// no push-to-pop bypass. Outputs read as zero while empty.
module btree_sched_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 34
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; push and pop may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents are only observed through a valid head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/btree_sched.sv
// Credit-based scheduler feeding a fixed-latency reduction tree from NREQ
// requesters and returning results in issue order through a response FIFO.
// Optional macro BTREE_SCHED_RR_EN selects round-robin arbitration; without
// it the lowest requester index always wins.
module btree_sched
  import btree_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*LANES*W-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tree_valid,
  output logic [LANES*W-1:0]      tree_data,
  input  logic [W-1:0]            tree_res,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [W-1:0]            rsp_data,
  input  logic                    rsp_ready
);

  localparam int VW  = LANES * W;
  localparam int CRW = $clog2(DEPTH + 1);

  if (DEPTH < LAT + 2) begin : g_bad_depth
    $error("btree_sched: DEPTH must be at least LAT+2");
  end

  logic [CRW-1:0]  credits_q;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic [VW-1:0]   gnt_data;
  logic            found;
  logic            accept;
  logic            pop;

  logic            tree_vld_p0;
  logic [ID_W-1:0] tree_id_p0;
  logic [LAT:1]    vld_pipe;
  logic [ID_W-1:0] id_pipe [1:LAT];
  logic [ID_W+W-1:0] fifo_out;

`ifdef BTREE_SCHED_RR_EN
  logic [ID_W-1:0] last_q;

  // Round-robin grant: search starts one past the last granted requester
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    if (credits_q != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req_valid[(int'(last_q) + k) % NREQ]) begin
          gnt[(int'(last_q) + k) % NREQ] = 1'b1;
          gnt_id = ID_W'((int'(last_q) + k) % NREQ);
          found  = 1'b1;
        end
      end
    end
  end

  // Pointer moves only when a request is actually taken
  always_ff @(posedge clk) begin
    if (rst)         last_q <= ID_W'(NREQ - 1);
    else if (accept) last_q <= gnt_id;
  end
`else
  // Fixed-priority grant: lowest requester index wins
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    if (credits_q != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i]) begin
          gnt[i] = 1'b1;
          gnt_id = ID_W'(i);
          found  = 1'b1;
        end
      end
    end
  end
`endif

  // Operand mux for the granted requester
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_data = req_data[i*VW +: VW];
    end
  end

  assign req_ready  = gnt;
  assign accept     = found;
  assign tree_valid = tree_vld_p0;
  assign pop        = rsp_valid && rsp_ready;

  // p0: tree issue register; operands hold between issues
  always_ff @(posedge clk) begin
    if (rst) begin
      tree_vld_p0 <= 1'b0;
      tree_data   <= '0;
    end else begin
      tree_vld_p0 <= accept;
      if (accept) tree_data <= gnt_data;
    end
  end

  // Requester id captured with the issue
  always_ff @(posedge clk) begin
    if (accept) tree_id_p0 <= gnt_id;
  end

  // p1..pLAT: valid delay line matching the tree latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= tree_vld_p0;
      for (int k = 2; k <= LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // p1..pLAT: id delay line riding with the valids
  always_ff @(posedge clk) begin
    id_pipe[1] <= tree_id_p0;
    for (int k = 2; k <= LAT; k++) id_pipe[k] <= id_pipe[k-1];
  end

  // Credits count free FIFO slots not yet claimed by in-flight issues
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= CRW'(DEPTH);
    end else if (accept && !pop) begin
      credits_q <= credits_q - 1'b1;
    end else if (pop && !accept) begin
      credits_q <= credits_q + 1'b1;
    end
  end

  btree_sched_fifo #(
    .DEPTH (DEPTH),
    .DW    (ID_W + W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[LAT]),
    .push_data ({id_pipe[LAT], tree_res}),
    .pop       (pop),
    .out_valid (rsp_valid),
    .out_data  (fifo_out)
  );

  assign rsp_id   = fifo_out[ID_W+W-1:W];
  assign rsp_data = fifo_out[W-1:0];

endmodule

// File: tb/tb_btree_sched.sv
// Bench for btree_sched: table-driven arbitration vectors, directed credit /
// reset sequences and randomized traffic against a transaction-level model.
module tb_btree_sched;

  localparam int W     = 32;
  localparam int LANES = 8;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;
  localparam int ID_W  = 2;
  localparam int VW    = LANES * W;
  localparam int DW    = NREQ * VW;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [DW-1:0]   req_data;
  logic [NREQ-1:0] req_ready;
  logic            tree_valid;
  logic [VW-1:0]   tree_data;
  logic [W-1:0]    tree_res;
  logic            rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_ready;

  always #5 clk = ~clk;

  btree_sched #(
    .W(W), .LANES(LANES), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tree_valid(tree_valid), .tree_data(tree_data),
    .tree_res(tree_res), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  function automatic logic [W-1:0] lane_sum(input logic [VW-1:0] v);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++) s = s + v[i*W +: W];
    return s;
  endfunction

  // Reduction tree model: sum of lanes, LAT cycles late; junk when idle
  logic [W-1:0] hist [LAT];
  always @(posedge clk) begin
    hist[0] <= tree_valid ? lane_sum(tree_data) : W'($urandom);
    for (int k = 1; k < LAT; k++) hist[k] <= hist[k-1];
  end
  assign tree_res = hist[LAT-1];

  // Transaction-level reference model
  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           rdy;
  } rsp_t;

  rsp_t          q[$];
  int            m_credits;
  int            m_last;
  logic          m_tv;
  logic [VW-1:0] m_td;
  int            cyc;
  int            checks;
  int            errors;

  function automatic void model_reset();
    q.delete();
    m_credits = DEPTH;
    m_last    = NREQ - 1;
    m_tv      = 1'b0;
    m_td      = '0;
  endfunction

  function automatic logic [NREQ-1:0] m_grant(input logic [NREQ-1:0] v);
    if (m_credits == 0) return '0;
`ifdef BTREE_SCHED_RR_EN
    for (int k = 1; k <= NREQ; k++)
      if (v[(m_last + k) % NREQ]) return NREQ'(1) << ((m_last + k) % NREQ);
`else
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return NREQ'(1) << i;
`endif
    return '0;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] d;
    for (int i = 0; i < NREQ * LANES; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check against model, advance model
  task automatic cycle(input logic [NREQ-1:0] v, input logic rr, input logic [DW-1:0] d,
                       output logic acc, output logic [NREQ-1:0] rdy_seen);
    logic [NREQ-1:0] g;
    logic            mrv;
    int              gid;
    req_valid = v;
    rsp_ready = rr;
    req_data  = d;
    #1;
    g   = m_grant(v);
    mrv = 1'b0;
    if (q.size() > 0) mrv = (q[0].rdy <= cyc);
    rdy_seen = req_ready;
    chk("req_ready", req_ready, g);
    chk("tree_valid", tree_valid, m_tv);
    chk("tree_data", tree_data, m_td);
    chk("rsp_valid", rsp_valid, mrv);
    if (mrv) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_data", rsp_data, q[0].data);
    end
    acc = (g != '0);
    gid = 0;
    for (int i = 0; i < NREQ; i++) if (g[i]) gid = i;
    @(posedge clk);
    m_tv = acc;
    if (acc) begin
      m_td = d[gid*VW +: VW];
      q.push_back('{gid, lane_sum(d[gid*VW +: VW]), cyc + LAT + 2});
      m_credits--;
      m_last = gid;
    end
    if (mrv && rr) begin
      void'(q.pop_front());
      m_credits++;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_tree_valid", tree_valid, 0);
    chk("rst_tree_data", tree_data, 0);
    req_valid = '1;
    #1;
    chk("rst_priority", req_ready, 4'b0001);
    req_valid = '0;
  endtask

  typedef struct {
    logic [NREQ-1:0] v;
    logic            rr;
    logic [NREQ-1:0] exp_rdy;
  } vec_t;

  vec_t            tbl [5];
  logic            acc;
  logic [NREQ-1:0] rs;
  int              n;
  int              lat_seen;
  logic [DW-1:0]   d;

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    model_reset();

`ifdef BTREE_SCHED_RR_EN
    tbl[0] = '{v: 4'hF, rr: 1'b1, exp_rdy: 4'b0001};
    tbl[1] = '{v: 4'hF, rr: 1'b1, exp_rdy: 4'b0010};
    tbl[2] = '{v: 4'hF, rr: 1'b1, exp_rdy: 4'b0100};
    tbl[3] = '{v: 4'hF, rr: 1'b1, exp_rdy: 4'b1000};
    tbl[4] = '{v: 4'hF, rr: 1'b1, exp_rdy: 4'b0001};
`else
    tbl[0] = '{v: 4'hA, rr: 1'b1, exp_rdy: 4'b0010};
    tbl[1] = '{v: 4'hA, rr: 1'b1, exp_rdy: 4'b0010};
    tbl[2] = '{v: 4'hA, rr: 1'b1, exp_rdy: 4'b0010};
    tbl[3] = '{v: 4'hA, rr: 1'b1, exp_rdy: 4'b0010};
    tbl[4] = '{v: 4'hC, rr: 1'b1, exp_rdy: 4'b0100};
`endif

    do_reset();

    // Arbitration vectors, then drain so ids and timing are checked
    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].v, tbl[i].rr, rand_vec(), acc, rs);
      chk("table_grant", rs, tbl[i].exp_rdy);
    end
    for (int i = 0; i < 10; i++) cycle('0, 1'b1, rand_vec(), acc, rs);
    chk("table_drained", q.size(), 0);

    // Credit exhaustion with output stalled
    do_reset();
    n = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(4'b0001, 1'b0, rand_vec(), acc, rs);
      if (acc) n++;
    end
    chk("credit_limit", n, DEPTH);
    cycle(4'b0001, 1'b1, rand_vec(), acc, rs);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(4'b0001, 1'b0, rand_vec(), acc, rs);
      if (acc) n++;
    end
    chk("one_pop_one_accept", n, 1);
    // Full FIFO released while the requester keeps streaming
    for (int i = 0; i < 20; i++) cycle(4'b0001, 1'b1, rand_vec(), acc, rs);
    for (int i = 0; i < 16; i++) cycle('0, 1'b1, rand_vec(), acc, rs);
    chk("full_drained", rsp_valid, 0);

    // Known sum: lanes 1..8 on requester 2
    do_reset();
    d = '0;
    for (int j = 0; j < LANES; j++) d[2*VW + j*W +: W] = W'(j + 1);
    cycle(4'b0100, 1'b1, d, acc, rs);
    lat_seen = -1;
    for (int k = 0; k < 20 && lat_seen < 0; k++) begin
      if (rsp_valid) begin
        chk("sum_data", rsp_data, 36);
        chk("sum_id", rsp_id, 2);
        lat_seen = k;
      end
      cycle('0, 1'b1, '0, acc, rs);
    end
    if (lat_seen < 0) chk("sum_timeout", 0, 1);
    else chk("sum_latency", lat_seen + 1, LAT + 2);

    // Reset with results queued and in flight
    do_reset();
    for (int i = 0; i < 5; i++) cycle(4'b0001, 1'b0, rand_vec(), acc, rs);
    cycle('0, 1'b0, rand_vec(), acc, rs);
    do_reset();
    for (int i = 0; i < 10; i++) cycle('0, 1'b1, rand_vec(), acc, rs);
    n = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(4'b0001, 1'b0, rand_vec(), acc, rs);
      if (acc) n++;
    end
    chk("credits_after_reset", n, DEPTH);

    // Randomized traffic with periods of back-pressure
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ((i / 40) % 3 == 2) cycle(NREQ'($urandom), ($urandom_range(0, 7) == 0), rand_vec(), acc, rs);
      else cycle(NREQ'($urandom), ($urandom_range(0, 3) != 0), rand_vec(), acc, rs);
    end
    for (int i = 0; i < 20; i++) cycle('0, 1'b1, rand_vec(), acc, rs);
    chk("random_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
